// File: rtl/puf_seq_pkg.sv
// Shared types and default parameters for the PUF challenge-response sequencer.
package puf_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSettle,
    StSample,
    StDone
  } puf_seq_state_e;

  localparam int unsigned DefCw           = 12;
  localparam int unsigned DefClrCycles    = 2;
  localparam int unsigned DefSettleCycles = 4;
  localparam int unsigned DefNumEvals     = 5;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, reset to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/puf_crp_sequencer.sv
// Challenge-response sequencer for one arbiter-PUF level: drives the challenge, pulses the
// PUF clear, samples the synchronised response NUM_EVALS times and reports a majority vote.
module puf_crp_sequencer
  import puf_seq_pkg::*;
#(
  parameter int unsigned CW            = DefCw,
  parameter int unsigned CLR_CYCLES    = DefClrCycles,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned NUM_EVALS     = DefNumEvals
) (
  input  logic                             i_clk,
  input  logic                             i_clr,
  input  logic                             i_req_valid,
  output logic                             o_req_ready,
  input  logic [CW-1:0]                    i_req_challenge,
  output logic [CW-1:0]                    o_puf_c,
  output logic                             o_puf_clr,
  input  logic                             i_puf_r,
  output logic                             o_rsp_valid,
  input  logic                             i_rsp_ready,
  output logic                             o_rsp_bit,
  output logic [$clog2(NUM_EVALS+1)-1:0]   o_rsp_ones,
  output logic                             o_rsp_stable,
  output logic                             o_busy
);

  localparam int unsigned OnesW = $clog2(NUM_EVALS + 1);
  localparam int unsigned EvalW = cnt_w(NUM_EVALS - 1);
  localparam int unsigned PhMax = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PhW   = cnt_w(PhMax - 1);

  // Reject illegal parameter sets at elaboration.
  if ((NUM_EVALS % 2) != 1) begin : g_err_num_evals
    $error("NUM_EVALS must be odd and at least 1");
  end
  if (SETTLE_CYCLES < 3) begin : g_err_settle
    $error("SETTLE_CYCLES must be at least 3 to cover the synchroniser");
  end
  if (CLR_CYCLES < 1) begin : g_err_clr
    $error("CLR_CYCLES must be at least 1");
  end

  puf_seq_state_e r_state, w_state_nxt;
  logic [PhW-1:0]   r_ph,   w_ph_nxt;
  logic [EvalW-1:0] r_eval, w_eval_nxt;
  logic [OnesW-1:0] r_ones, w_ones_nxt;
  logic [CW-1:0]    r_c,    w_c_nxt;
  logic             w_r_sync;
  logic             w_done;

  sync_2ff u_sync (
    .i_clk (i_clk),
    .i_clr (i_clr),
    .i_d   (i_puf_r),
    .o_q   (w_r_sync)
  );

  // State and counter registers; clr wins over any handshake.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= StIdle;
      r_ph    <= '0;
      r_eval  <= '0;
      r_ones  <= '0;
      r_c     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ph    <= w_ph_nxt;
      r_eval  <= w_eval_nxt;
      r_ones  <= w_ones_nxt;
      r_c     <= w_c_nxt;
    end
  end

  // Next-state logic: phase counter restarts at zero on every state entry.
  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    w_eval_nxt  = r_eval;
    w_ones_nxt  = r_ones;
    w_c_nxt     = r_c;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_c_nxt     = i_req_challenge;
          w_eval_nxt  = '0;
          w_ones_nxt  = '0;
          w_ph_nxt    = '0;
          w_state_nxt = StClear;
        end
      end
      StClear: begin
        if (r_ph == PhW'(CLR_CYCLES - 1)) begin
          w_ph_nxt    = '0;
          w_state_nxt = StSettle;
        end else begin
          w_ph_nxt = r_ph + 1'b1;
        end
      end
      StSettle: begin
        if (r_ph == PhW'(SETTLE_CYCLES - 1)) begin
          w_ph_nxt    = '0;
          w_state_nxt = StSample;
        end else begin
          w_ph_nxt = r_ph + 1'b1;
        end
      end
      StSample: begin
        w_ones_nxt = r_ones + OnesW'(w_r_sync);
        w_ph_nxt   = '0;
        if (r_eval == EvalW'(NUM_EVALS - 1)) begin
          w_state_nxt = StDone;
        end else begin
          w_eval_nxt  = r_eval + 1'b1;
          w_state_nxt = StClear;
        end
      end
      StDone: begin
        if (i_rsp_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Outputs decoded from the registered state; response fields are zero outside DONE.
  always_comb begin
    w_done       = (r_state == StDone);
    o_req_ready  = (r_state == StIdle);
    o_busy       = (r_state != StIdle);
    o_puf_clr    = (r_state == StIdle) || (r_state == StClear) || (r_state == StDone);
    o_puf_c      = r_c;
    o_rsp_valid  = w_done;
    o_rsp_ones   = w_done ? r_ones : '0;
    o_rsp_bit    = w_done && (r_ones > OnesW'(NUM_EVALS / 2));
    o_rsp_stable = w_done && ((r_ones == '0) || (r_ones == OnesW'(NUM_EVALS)));
  end

endmodule

// File: doc/puf_crp_sequencer.md
# puf_crp_sequencer

Challenge–response sequencer for one feed-forward arbiter PUF level. Accepts a challenge over a valid/ready handshake, drives it onto the PUF's challenge bus, and pulses the PUF clear. It then samples the synchronised PUF response NUM_EVALS times and returns a majority-voted response bit plus a stability flag over a second valid/ready handshake. It sits between the PUF level and the enrolment/authentication logic and is the only driver of the PUF's clear and challenge inputs.

## Interface
- CW, 12, challenge width; matches the PUF level's challenge bus.
- CLR_CYCLES, 2, cycles puf_clr is held high before each evaluation; must be ≥1.
- SETTLE_CYCLES, 4, cycles after puf_clr falls before sampling; must be ≥3, which covers the 2-flop synchroniser.
- NUM_EVALS, 5, evaluations per challenge; odd, ≥1.

- clk  in  1  single clock for the whole block.
- clr  in  1  synchronous, active-high reset.
- req_valid  in  1  challenge request valid.
- req_ready  out  1  high only in IDLE.
- req_challenge  in  CW  challenge; captured on the req handshake.
- puf_c  out  CW  challenge to the PUF level; held stable from capture until leaving DONE.
- puf_clr  out  1  clear to the PUF level.
- puf_r  in  1  raw PUF response from the SR latch; asynchronous to clk.
- rsp_valid  out  1  response valid; held until accepted.
- rsp_ready  in  1  consumer ready.
- rsp_bit  out  1  majority-voted response.
- rsp_ones  out  $clog2(NUM_EVALS+1)  count of evaluations that returned 1.
- rsp_stable  out  1  all evaluations agreed.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, CLEAR, SETTLE, SAMPLE, DONE.
- IDLE
  - puf_clr=1, req_ready=1.
  - On req_valid&&req_ready: latch req_challenge into puf_c, zero eval_cnt and ones_cnt, go to CLEAR.
- CLEAR
  - puf_clr=1 for CLR_CYCLES cycles, then go to SETTLE.
- SETTLE
  - puf_clr=0 for SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE
  - One cycle; puf_clr=0.
  - ones_cnt += puf_r_sync.
  - If eval_cnt==NUM_EVALS-1, go to DONE; otherwise eval_cnt++ and go to CLEAR.
- DONE
  - puf_clr=1, rsp_valid=1.
  - rsp_bit = (ones_cnt > NUM_EVALS/2).
  - rsp_stable = (ones_cnt==0 || ones_cnt==NUM_EVALS).
  - rsp_ones = ones_cnt.
  - On rsp_ready, go to IDLE.
- puf_r always passes through a 2-flop synchroniser; only the synchronised value is sampled.
- Counters saturate-free: every counter width is $clog2(max+1) and each counter is cleared on state entry.

## Timing
- Reset values:
  - state=IDLE, puf_clr=1, puf_c=0, req_ready=1.
  - rsp_valid=0, rsp_bit=0, rsp_ones=0, rsp_stable=0, busy=0.
  - Synchroniser flops=0.
- Per evaluation: CLR_CYCLES+SETTLE_CYCLES+1 cycles.
- Latency: rsp_valid rises NUM_EVALS×(CLR_CYCLES+SETTLE_CYCLES+1) cycles after the req handshake edge; 35 cycles at the defaults.
- puf_c changes only on the req handshake edge; no change while busy.
- req_valid is ignored while busy; the request is not captured and no error is raised.
- rsp outputs stay stable while rsp_valid=1 && rsp_ready=0.
- Back-to-back: after the rsp handshake the state is IDLE on the next cycle. There is no same-cycle bypass, so the minimum gap between responses is latency+1.
- clr mid-operation: on the next edge the block is in IDLE with all reset values, and any partial result is discarded.
- clr wins over every simultaneous handshake.

## Structure
- Package puf_seq_pkg holds:
  - the state enum (IDLE, CLEAR, SETTLE, SAMPLE, DONE);
  - default constants for CW, CLR_CYCLES, SETTLE_CYCLES and NUM_EVALS.
- Sub-module sync_2ff (1-bit, reset to 0) synchronises puf_r.
- Parameter legality is checked at elaboration: NUM_EVALS odd, SETTLE_CYCLES≥3, CLR_CYCLES≥1.

## Test plan
- Reset, then idle for 10 cycles → puf_clr=1, req_ready=1, rsp_valid=0, busy=0 throughout.
- Challenge 12'hA5C, puf_r tied 1 → rsp_valid 35 cycles after the handshake; rsp_bit=1, rsp_ones=5, rsp_stable=1; puf_c=12'hA5C for the whole transaction.
- Eval results 1,0,1,0,0 (model drives puf_r per eval) → rsp_bit=0, rsp_ones=2, rsp_stable=0.
- rsp_ready held low for 20 cycles after rsp_valid, with a new req_valid asserted meanwhile → response held constant, req_ready=0, new challenge not captured until 1 cycle after the rsp handshake.
- clr asserted at cycle 12 of a transaction → next cycle IDLE, puf_clr=1, rsp_valid never asserted; a following request completes normally in 35 cycles.
- puf_clr waveform check at defaults → per eval exactly 2 cycles high, then 5 cycles low (4 SETTLE + 1 SAMPLE), repeated 5 times.
